// File: rtl/perceptron_seq_if.sv
// perceptron_seq_if: vector-in / decision-out handshake bundle for perceptron_seq
interface perceptron_seq_if #(
    parameter int N_IN  = 4,
    parameter int IN_W  = 8,
    parameter int ACC_W = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N_IN*IN_W-1:0]    in_vec;
    logic                    train;
    logic                    desired_out;
    logic                    out_valid;
    logic                    out;
    logic signed [ACC_W-1:0] acc_out;
    modport master(output in_valid, in_vec, train, desired_out, input in_ready, out_valid, out, acc_out);
    modport slave(input in_valid, in_vec, train, desired_out, output in_ready, out_valid, out, acc_out);
endinterface

// File: rtl/perceptron_seq.sv
// perceptron_seq: sequential one-multiplier perceptron with online training; PERCEPTRON_WEIGHT_LOAD_EN adds a weight/threshold load port
module perceptron_seq #(
    parameter int N_IN        = 4,
    parameter int IN_W        = 8,
    parameter int W_W         = 16,
    parameter int ACC_W       = 32,
    parameter int LR_SHIFT    = 3,
    parameter int W_INIT      = 10,
    parameter int THRESH_INIT = 200
) (
    input logic                          clk,
    input logic                          reset,
`ifdef PERCEPTRON_WEIGHT_LOAD_EN
    input logic                          wl_en,
    input logic [$clog2(N_IN+1)-1:0]     wl_idx,
    input logic signed [W_W-1:0]         wl_data,
`endif
    perceptron_seq_if.slave              bus
);
    localparam int IW = $clog2(N_IN);
    localparam int PW = IN_W + W_W + 1;
    localparam int SW = W_W + IN_W + 2;
    localparam logic signed [SW-1:0] W_MAX = SW'((1 << (W_W - 1)) - 1);
    localparam logic signed [SW-1:0] W_MIN = ~W_MAX;
    typedef enum logic [1:0] {IDLE, MAC, DECIDE, UPDATE} state_t;
    state_t                  state;
    logic [IW-1:0]           idx;
    logic [N_IN*IN_W-1:0]    vec_q;
    logic                    train_q, des_q;
    logic signed [ACC_W-1:0] acc, acc_next, thr_ext;
    logic signed [W_W-1:0]   w [N_IN];
    logic signed [W_W-1:0]   thr;
    logic [IN_W-1:0]         cur_in;
    logic signed [PW-1:0]    prod;
    logic signed [SW-1:0]    delta, w_sum, t_sum;
    logic                    load, accept, last;
    function automatic logic signed [W_W-1:0] sat(input logic signed [SW-1:0] v);
        return v > W_MAX ? W_MAX[W_W-1:0] : v < W_MIN ? W_MIN[W_W-1:0] : v[W_W-1:0];
    endfunction
`ifdef PERCEPTRON_WEIGHT_LOAD_EN
    localparam int LW = $clog2(N_IN + 1);
    assign load = wl_en && state == IDLE && wl_idx <= LW'(N_IN);
`else
    assign load = 1'b0;
`endif
    // a weight load in IDLE takes priority over accepting a vector
    assign bus.in_ready = state == IDLE && !load;
    assign accept = bus.in_valid && bus.in_ready;
    assign last = idx == IW'(N_IN - 1);
    always_comb begin
        cur_in = vec_q[idx*IN_W +: IN_W];
        prod = $signed({1'b0, cur_in}) * w[idx];
        acc_next = acc + ACC_W'(prod);
        thr_ext = ACC_W'(thr);
        delta = SW'(cur_in >> LR_SHIFT);
        w_sum = SW'(w[idx]) + (des_q ? delta : -delta);
        t_sum = SW'(thr) + (des_q ? -SW'(1) : SW'(1));
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx <= '0;
            acc <= '0;
            vec_q <= '0;
            train_q <= 1'b0;
            des_q <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out <= 1'b0;
            bus.acc_out <= '0;
            thr <= W_W'(THRESH_INIT);
            for (int i = 0; i < N_IN; i++) w[i] <= W_W'(W_INIT);
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        vec_q <= bus.in_vec;
                        train_q <= bus.train;
                        des_q <= bus.desired_out;
                        acc <= '0;
                        idx <= '0;
                        state <= MAC;
                    end
`ifdef PERCEPTRON_WEIGHT_LOAD_EN
                    if (load) begin
                        if (wl_idx == LW'(N_IN)) thr <= wl_data;
                        else w[wl_idx[IW-1:0]] <= wl_data;
                    end
`endif
                end
                MAC: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    // the decision is registered on the last product so out_valid coincides with DECIDE
                    if (last) begin
                        bus.out_valid <= 1'b1;
                        bus.out <= acc_next >= thr_ext;
                        bus.acc_out <= acc_next;
                        idx <= '0;
                        state <= DECIDE;
                    end
                end
                DECIDE: state <= (train_q && bus.out != des_q) ? UPDATE : IDLE;
                UPDATE: begin
                    w[idx] <= sat(w_sum);
                    idx <= idx + 1'b1;
                    if (last) begin
                        thr <= sat(t_sum);
                        idx <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_perceptron_seq.sv
// tb_perceptron_seq: randomized and directed checks of perceptron_seq against an arithmetic reference model
module tb_perceptron_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    perceptron_seq_if #(.N_IN(4), .IN_W(8), .ACC_W(32)) ifa ();
    perceptron_seq_if #(.N_IN(4), .IN_W(8), .ACC_W(32)) ifb ();
    perceptron_seq u_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    perceptron_seq #(.W_W(8), .LR_SHIFT(0), .W_INIT(-100), .THRESH_INIT(127)) u_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    int mw[4];
    int mthr;
    function automatic int clamp16(input int v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction
    task automatic model_reset();
        foreach (mw[i]) mw[i] = 10;
        mthr = 200;
    endtask
    // decision = dot(in, w) >= threshold; wrong trained decisions move weights by in>>3 and threshold by 1
    task automatic model_run(input logic [31:0] v, input logic tr, input logic de, output int acc, output logic o, output logic upd);
        acc = 0;
        for (int i = 0; i < 4; i++) acc += int'(v[i*8 +: 8]) * mw[i];
        o = acc >= mthr;
        upd = tr && (o != de);
        if (upd) begin
            for (int i = 0; i < 4; i++) mw[i] = clamp16(mw[i] + (de ? 1 : -1) * int'(v[i*8 +: 8] >> 3));
            mthr = clamp16(mthr + (de ? -1 : 1));
        end
    endtask

    task automatic send_a(input logic [31:0] v, input logic tr, input logic de, output logic o, output int acc, output int lat, output int rdy);
        int n = 0;
        @(negedge clk);
        while (!ifa.in_ready && n < 40) begin @(negedge clk); n++; end
        ifa.in_vec = v; ifa.train = tr; ifa.desired_out = de; ifa.in_valid = 1'b1;
        @(posedge clk);
        #1 ifa.in_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ifa.out_valid && lat < 40);
        o = ifa.out;
        acc = ifa.acc_out;
        rdy = 0;
        do begin @(negedge clk); rdy++; end while (!ifa.in_ready && rdy < 40);
    endtask
    task automatic send_b(input logic [31:0] v, input logic tr, input logic de, output logic o, output int acc);
        int n = 0;
        @(negedge clk);
        while (!ifb.in_ready && n < 40) begin @(negedge clk); n++; end
        ifb.in_vec = v; ifb.train = tr; ifb.desired_out = de; ifb.in_valid = 1'b1;
        @(posedge clk);
        #1 ifb.in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!ifb.out_valid && n < 40);
        o = ifb.out;
        acc = ifb.acc_out;
        n = 0;
        do begin @(negedge clk); n++; end while (!ifb.in_ready && n < 40);
    endtask

    task automatic test_reset();
        logic o, eo, upd;
        int acc, eacc, lat, rdy;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ifa.in_ready); end
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ifa.out_valid); end
        checks++; if (ifa.out !== 1'b0) begin errors++; $display("FAIL reset_out got %b want 0", ifa.out); end
        checks++; if (ifa.acc_out !== 32'sd0) begin errors++; $display("FAIL reset_acc_out got %0d want 0", ifa.acc_out); end
        @(negedge clk) reset = 1'b1;
        model_reset();
        model_run(32'h0000_0001, 1'b0, 1'b0, eacc, eo, upd);
        send_a(32'h0000_0001, 1'b0, 1'b0, o, acc, lat, rdy);
        checks++; if (acc !== eacc) begin errors++; $display("FAIL reset_w_init acc got %0d want %0d", acc, eacc); end
    endtask

    task automatic test_basic();
        logic [31:0] vecs[3] = '{32'h0000_050A, 32'h0000_0014, 32'h0000_0013};
        logic o, eo, upd;
        int acc, eacc, lat, rdy;
        for (int k = 0; k < 3; k++) begin
            model_run(vecs[k], 1'b0, 1'b0, eacc, eo, upd);
            send_a(vecs[k], 1'b0, 1'b0, o, acc, lat, rdy);
            checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 5", k, lat); end
            checks++; if (acc !== eacc) begin errors++; $display("FAIL basic_acc[%0d] got %0d want %0d", k, acc, eacc); end
            checks++; if (o !== eo) begin errors++; $display("FAIL basic_out[%0d] got %b want %b", k, o, eo); end
            checks++; if (rdy !== 1) begin errors++; $display("FAIL basic_ready[%0d] got %0d want 1", k, rdy); end
        end
    endtask

    task automatic test_train();
        logic [31:0] vecs[3] = '{32'h0004_0810, 32'h0004_0810, 32'h1400_0000};
        logic trs[3] = '{1'b1, 1'b0, 1'b0};
        logic o, eo, upd;
        int acc, eacc, lat, rdy;
        for (int k = 0; k < 3; k++) begin
            model_run(vecs[k], trs[k], 1'b0, eacc, eo, upd);
            send_a(vecs[k], trs[k], 1'b0, o, acc, lat, rdy);
            checks++; if (acc !== eacc) begin errors++; $display("FAIL train_acc[%0d] got %0d want %0d", k, acc, eacc); end
            checks++; if (o !== eo) begin errors++; $display("FAIL train_out[%0d] got %b want %b", k, o, eo); end
            checks++; if (rdy !== (upd ? 5 : 1)) begin errors++; $display("FAIL train_ready[%0d] got %0d want %0d", k, rdy, upd ? 5 : 1); end
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic tr, de, o, eo, upd;
        int acc, eacc, lat, rdy;
        for (int k = 0; k < 40; k++) begin
            v = $urandom;
            tr = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            model_run(v, tr, de, eacc, eo, upd);
            send_a(v, tr, de, o, acc, lat, rdy);
            checks++; if (lat !== 5 || acc !== eacc || o !== eo || rdy !== (upd ? 5 : 1)) begin
                errors++;
                $display("FAIL random[%0d] vec %h lat/acc/out/rdy got %0d/%0d/%b/%0d want 5/%0d/%b/%0d", k, v, lat, acc, o, rdy, eacc, eo, upd ? 5 : 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va, vb;
        logic o, upd;
        int ea, eb, pulses, t[2], a[2];
        va = $urandom; vb = $urandom;
        model_run(va, 1'b0, 1'b0, ea, o, upd);
        model_run(vb, 1'b0, 1'b0, eb, o, upd);
        pulses = 0; t = '{0, 0}; a = '{0, 0};
        @(negedge clk);
        ifa.in_vec = va; ifa.train = 1'b0; ifa.in_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ifa.out_valid) begin
                if (pulses < 2) begin t[pulses] = c; a[pulses] = ifa.acc_out; end
                pulses++;
            end
            ifa.in_vec = c < 6 ? $urandom : vb;
            if (c == 7) ifa.in_valid = 1'b0;
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
        checks++; if (t[0] !== 5 || t[1] !== 11) begin errors++; $display("FAIL b2b_timing got %0d,%0d want 5,11", t[0], t[1]); end
        checks++; if (a[0] !== ea) begin errors++; $display("FAIL b2b_first_acc got %0d want %0d", a[0], ea); end
        checks++; if (a[1] !== eb) begin errors++; $display("FAIL b2b_second_acc got %0d want %0d", a[1], eb); end
    endtask

    task automatic test_abort();
        logic [31:0] vecs[2] = '{32'h0101_0101, 32'hFFFF_FFFF};
        int waits[2] = '{1, 7};
        logic o, eo, upd;
        int acc, eacc, lat, rdy, pulses;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ifa.in_vec = vecs[k]; ifa.train = 1'b1; ifa.desired_out = 1'b0; ifa.in_valid = 1'b1;
            @(posedge clk);
            #1 ifa.in_valid = 1'b0;
            repeat (waits[k]) @(posedge clk);
            #2 reset = 1'b0;
            @(negedge clk);
            pulses = 0;
            @(negedge clk) reset = 1'b1;
            for (int c = 0; c < 12; c++) begin @(negedge clk); if (ifa.out_valid) pulses++; end
            checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pulse[%0d] got %0d want 0", k, pulses); end
            checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready[%0d] got %b want 1", k, ifa.in_ready); end
            model_reset();
            model_run(32'h0000_00FF, 1'b0, 1'b0, eacc, eo, upd);
            send_a(32'h0000_00FF, 1'b0, 1'b0, o, acc, lat, rdy);
            checks++; if (acc !== eacc) begin errors++; $display("FAIL abort_weights[%0d] acc got %0d want %0d", k, acc, eacc); end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] vecs[5] = '{32'h0000_00FF, 32'h0000_00FF, 32'h0000_FFFF, 32'h0000_FF00, 32'h0000_00FF};
        logic trs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic des[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int eacc[5] = '{-25500, 32385, 6885, -32640, -32640};
        logic eo[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic o;
        int acc;
        for (int k = 0; k < 5; k++) begin
            send_b(vecs[k], trs[k], des[k], o, acc);
            checks++; if (acc !== eacc[k]) begin errors++; $display("FAIL sat_acc[%0d] got %0d want %0d", k, acc, eacc[k]); end
            checks++; if (o !== eo[k]) begin errors++; $display("FAIL sat_out[%0d] got %b want %b", k, o, eo[k]); end
        end
    endtask

    initial begin
        ifa.in_valid = 1'b0; ifa.in_vec = '0; ifa.train = 1'b0; ifa.desired_out = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_vec = '0; ifb.train = 1'b0; ifb.desired_out = 1'b0;
        test_reset();
        test_basic();
        test_train();
        test_random();
        test_back_to_back();
        test_abort();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
